// File: rtl/pixel_sensor_pkg.sv
// rtl/pixel_sensor_pkg.sv - state codes, per-state output sets and sizing helpers for the frame sequencer
package pixel_sensor_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_ERASE   = 3'd1;
  localparam state_t S_EXPOSE  = 3'd2;
  localparam state_t S_CONVERT = 3'd3;
  localparam state_t S_HOLD    = 3'd4;
  localparam state_t S_READ    = 3'd5;
  localparam state_t S_DONE    = 3'd6;

  typedef struct packed {
    logic busy;
    logic power_enable;
    logic erase;
    logic expose;
    logic counter_reset;
    logic convert_enable;
    logic write_enable;
    logic read_reset;
    logic read_enable;
    logic frame_done;
  } outs_t;

  // Field order: busy, power, erase, expose, counter_reset, convert, write_enable, read_reset, read_enable, done
  localparam outs_t OUT_IDLE    = 10'b0_0_0_0_0_0_1_0_0_0;
  localparam outs_t OUT_ERASE   = 10'b1_1_1_0_1_0_1_0_0_0;
  localparam outs_t OUT_EXPOSE  = 10'b1_1_0_1_0_0_1_0_0_0;
  localparam outs_t OUT_CONVERT = 10'b1_1_0_0_0_1_1_0_0_0;
  localparam outs_t OUT_HOLD    = 10'b1_0_0_0_0_0_0_1_0_0;
  localparam outs_t OUT_READ    = 10'b1_0_0_0_0_0_0_0_1_0;
  localparam outs_t OUT_DONE    = 10'b1_0_0_0_0_0_0_0_0_1;

  function automatic outs_t state_outputs(input state_t s);
    case (s)
      S_ERASE:   return OUT_ERASE;
      S_EXPOSE:  return OUT_EXPOSE;
      S_CONVERT: return OUT_CONVERT;
      S_HOLD:    return OUT_HOLD;
      S_READ:    return OUT_READ;
      S_DONE:    return OUT_DONE;
      default:   return OUT_IDLE;
    endcase
  endfunction

  function automatic int read_beats(input int w, input int h, input int p);
    return (w * h + p - 1) / p;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pixel_sensor_sequencer_phase_counter.sv
// rtl/pixel_sensor_sequencer_phase_counter.sv - loadable down-counter that parks at zero and flags it
module phase_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pixel_sensor_sequencer.sv
// rtl/pixel_sensor_sequencer.sv - per-frame erase/expose/convert/hold/read sequencer for the pixel array
module pixel_sensor_sequencer
  import pixel_sensor_pkg::*;
#(
  parameter int WIDTH                  = 3,
  parameter int HEIGHT                 = 3,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 3,
  parameter int BIT_DEPTH              = 10,
  parameter int ERASE_CYCLES           = 5,
  parameter int EXP_W                  = 16,
  localparam int READ_BEATS = read_beats(WIDTH, HEIGHT, OUTPUT_BUS_PIXEL_WIDTH),
  localparam int RBW        = $clog2(READ_BEATS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [EXP_W-1:0] exposure_time_i,
  output logic             power_enable_o,
  output logic             erase_o,
  output logic             expose_o,
  output logic             counter_reset_o,
  output logic             convert_enable_o,
  output logic             write_enable_o,
  output logic             read_reset_o,
  output logic             read_enable_o,
  output logic [RBW-1:0]   read_beat_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  localparam int CW = max2(max2(EXP_W, BIT_DEPTH + 1),
                           max2($clog2(ERASE_CYCLES + 1), $clog2(READ_BEATS + 1)));

  state_t           state_q, state_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [RBW-1:0]   beat_q, beat_d;
  outs_t            outs_q;
  logic             load;
  logic [CW-1:0]    load_val;
  logic             phase_zero;

  phase_counter #(.W(CW)) u_phase (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (load),
    .load_val_i (load_val),
    .zero_o     (phase_zero)
  );

  // Each transition loads the next phase's length minus one so the counter hits zero on its last cycle.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    beat_d   = beat_q;
    load     = 1'b0;
    load_val = '0;
    if (state_q != S_IDLE && abort_i) begin
      state_d = S_IDLE;
      beat_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            state_d  = S_ERASE;
            exp_d    = exposure_time_i;
            load     = 1'b1;
            load_val = CW'(ERASE_CYCLES - 1);
          end
        end
        S_ERASE: begin
          if (phase_zero) begin
            state_d  = S_EXPOSE;
            load     = 1'b1;
            load_val = (exp_q == '0) ? '0 : CW'(exp_q) - CW'(1);
          end
        end
        S_EXPOSE: begin
          if (phase_zero) begin
            state_d  = S_CONVERT;
            load     = 1'b1;
            load_val = CW'((2 ** BIT_DEPTH) - 1);
          end
        end
        S_CONVERT: begin
          if (phase_zero) begin
            state_d = S_HOLD;
            load    = 1'b1;
          end
        end
        S_HOLD: begin
          state_d  = S_READ;
          beat_d   = '0;
          load     = 1'b1;
          load_val = CW'(READ_BEATS - 1);
        end
        S_READ: begin
          if (phase_zero) begin
            state_d = S_DONE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + RBW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      beat_q  <= '0;
      outs_q  <= OUT_IDLE;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      beat_q  <= beat_d;
      outs_q  <= state_outputs(state_d);
    end
  end

  assign power_enable_o   = outs_q.power_enable;
  assign erase_o          = outs_q.erase;
  assign expose_o         = outs_q.expose;
  assign counter_reset_o  = outs_q.counter_reset;
  assign convert_enable_o = outs_q.convert_enable;
  assign write_enable_o   = outs_q.write_enable;
  assign read_reset_o     = outs_q.read_reset;
  assign read_enable_o    = outs_q.read_enable;
  assign read_beat_o      = beat_q;
  assign busy_o           = outs_q.busy;
  assign frame_done_o     = outs_q.frame_done;

endmodule

// File: tb/tb_pixel_sensor_sequencer.sv
// tb/tb_pixel_sensor_sequencer.sv - frame-timing model, per-cycle compare and directed/random frames
module tb_pixel_sensor_sequencer;

  localparam int ERASE_C = 5;
  localparam int CONV_C  = 1024;
  localparam int RB      = 3;

  localparam int B_BUSY = 11, B_POWER = 10, B_ERASE = 9, B_EXPOSE = 8, B_CRST = 7;
  localparam int B_CONV = 6, B_WE = 5, B_RRST = 4, B_REN = 3, B_DONE = 2, B_BEAT = -1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] exp_t = '0;

  logic power_o, erase_o, expose_o, crst_o, conv_o, we_o, rrst_o, ren_o, busy_o, done_o;
  logic [1:0] beat_o;

  int tests = 0;
  int fails = 0;

  pixel_sensor_sequencer dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .start_i          (start),
    .abort_i          (abort),
    .exposure_time_i  (exp_t),
    .power_enable_o   (power_o),
    .erase_o          (erase_o),
    .expose_o         (expose_o),
    .counter_reset_o  (crst_o),
    .convert_enable_o (conv_o),
    .write_enable_o   (we_o),
    .read_reset_o     (rrst_o),
    .read_enable_o    (ren_o),
    .read_beat_o      (beat_o),
    .busy_o           (busy_o),
    .frame_done_o     (done_o)
  );

  always #5 clk = ~clk;

  logic [11:0] dut_vec;
  assign dut_vec = {busy_o, power_o, erase_o, expose_o, crst_o, conv_o, we_o, rrst_o, ren_o, done_o, beat_o};

  // Model: a frame is "active" with n = cycles since the accepting edge and e = effective exposure.
  bit m_act = 1'b0;
  int m_n   = 0;
  int m_e   = 1;

  function automatic int frame_len(input int e);
    return ERASE_C + e + CONV_C + 1 + RB + 1;
  endfunction

  function automatic logic [11:0] model_out(input bit act, input int n, input int e);
    int a, b, c, h, r;
    logic [11:0] v;
    v = '0;
    if (!act) begin
      v[B_WE] = 1'b1;
      return v;
    end
    a = ERASE_C; b = a + e; c = b + CONV_C; h = c + 1; r = h + RB;
    v[B_BUSY] = 1'b1;
    if (n <= a) begin
      v[B_POWER] = 1; v[B_ERASE] = 1; v[B_CRST] = 1; v[B_WE] = 1;
    end else if (n <= b) begin
      v[B_POWER] = 1; v[B_EXPOSE] = 1; v[B_WE] = 1;
    end else if (n <= c) begin
      v[B_POWER] = 1; v[B_CONV] = 1; v[B_WE] = 1;
    end else if (n == h) begin
      v[B_RRST] = 1;
    end else if (n <= r) begin
      v[B_REN] = 1;
      v[1:0] = 2'(n - h - 1);
    end else begin
      v[B_DONE] = 1;
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0;
    end else if (m_act) begin
      if (abort || m_n >= frame_len(m_e)) m_act = 1'b0;
      else m_n = m_n + 1;
    end else if (start && !abort) begin
      m_act = 1'b1;
      m_n   = 1;
      m_e   = (exp_t == 16'd0) ? 1 : int'(exp_t);
    end
  end

  always @(negedge clk) begin
    logic [11:0] want;
    want = model_out(m_act, m_n, m_e);
    tests++;
    if (dut_vec !== want) begin
      fails++;
      $display("FAIL cycle_outputs t=%0t: got %b expected %b", $time, dut_vec, want);
    end
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, got, want);
    end
  endtask

  function automatic int sig_val(input logic [11:0] v, input int s);
    if (s < 0) return int'(v[1:0]);
    return int'(v[s]);
  endfunction

  typedef struct {
    int n;
    int s;
    int v;
  } lit_t;
  lit_t lits[$];

  task automatic add_lit(input int n, input int s, input int v);
    lit_t l;
    l.n = n; l.s = s; l.v = v;
    lits.push_back(l);
  endtask

  task automatic add_frame1_lits();
    add_lit(1, B_ERASE, 1);  add_lit(1, B_CRST, 1);    add_lit(1, B_POWER, 1);
    add_lit(5, B_ERASE, 1);  add_lit(6, B_ERASE, 0);   add_lit(6, B_EXPOSE, 1);
    add_lit(15, B_EXPOSE, 1); add_lit(16, B_CONV, 1);  add_lit(1039, B_CONV, 1);
    add_lit(1040, B_RRST, 1); add_lit(1040, B_WE, 0);  add_lit(1041, B_REN, 1);
    add_lit(1041, B_BEAT, 0); add_lit(1043, B_BEAT, 2); add_lit(1044, B_DONE, 1);
    add_lit(1045, B_BUSY, 0); add_lit(1045, B_WE, 1);
  endtask

  // Called and returns at a falling edge; cycle n is observed at the n-th falling edge after acceptance.
  task automatic run_frame(input int e, input int ncyc, input int abort_at,
                           input int restart_at, input int reset_at, input bit hold);
    start = 1'b1;
    exp_t = 16'(e);
    @(posedge clk);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      foreach (lits[i]) if (lits[i].n == n) check("literal", sig_val(dut_vec, lits[i].s), lits[i].v);
      start = hold || (n == restart_at);
      if (n == restart_at) exp_t = 16'd99;
      abort = (n == abort_at);
      if (n == reset_at) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_we", int'(we_o), 1);
        check("async_reset_ren", int'(ren_o), 0);
        check("async_reset_busy", int'(busy_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
    end
    lits.delete();
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_we", int'(we_o), 1);
    check("reset_busy", int'(busy_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    add_frame1_lits();
    run_frame(10, 1050, 0, 0, 0, 1'b0);

    add_lit(5, B_ERASE, 1); add_lit(6, B_EXPOSE, 1); add_lit(7, B_EXPOSE, 0); add_lit(7, B_CONV, 1);
    run_frame(0, 1040, 0, 0, 0, 1'b0);

    add_lit(500, B_CONV, 1); add_lit(501, B_BUSY, 0); add_lit(501, B_WE, 1); add_lit(502, B_DONE, 0);
    run_frame(10, 520, 500, 0, 0, 1'b0);

    add_frame1_lits();
    run_frame(10, 1050, 0, 8, 0, 1'b0);

    add_lit(1042, B_REN, 1);
    run_frame(10, 1050, 0, 0, 1042, 1'b0);
    add_frame1_lits();
    run_frame(10, 1050, 0, 0, 0, 1'b0);

    add_lit(1044, B_DONE, 1); add_lit(1045, B_BUSY, 0); add_lit(1046, B_ERASE, 1); add_lit(2089, B_DONE, 1);
    run_frame(10, 2095, 0, 0, 0, 1'b1);

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start", int'(busy_o), 0);
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      int e, ab, rs;
      e  = $urandom_range(0, 30);
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 1070) : 0;
      rs = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 1000) : 0;
      run_frame(e, 1075, ab, rs, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
